karat_div: RTL and testbench

//   Iterative radix-2 restoring divider; the inverse of karat_mult. Splits a wO-bit

---
 rtl/karat_pkg.sv | 13 +
 rtl/karat_div_step.sv | 23 ++
 rtl/karat_div.sv | 113 +++++++++++
 tb/tb_karat_div.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/karat_pkg.sv
// Shared definitions for the karat multiplier/divider pair.
// Holds the common handshake state encoding and the default operand width.
package karat_pkg;

    localparam int KARAT_WI = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } karat_state_e;

endpackage

// File: rtl/karat_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// then subtract the divisor when it fits.
module karat_div_step #(
    parameter int wI = 64
) (
    input  logic [wI-1:0] rem,
    input  logic          msb,
    input  logic [wI-1:0] y,
    output logic [wI-1:0] rem_next,
    output logic          qbit
);

    logic [wI:0] t;

    // When t >= y the difference is below 2^wI, so the low wI bits of the
    // wrap-around subtraction are exact.
    always_comb begin
        t        = {rem, msb};
        qbit     = (t >= {1'b0, y});
        rem_next = qbit ? (t[wI-1:0] - y) : t[wI-1:0];
    end

endmodule

// File: rtl/karat_div.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides and one division in flight.
module karat_div
    import karat_pkg::*;
#(
    parameter int wI = KARAT_WI,
    parameter int wO = 2 * wI
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic [wO-1:0] iO,
    input  logic [wI-1:0] iY,
    output logic          oValid,
    input  logic          iReady,
    output logic [wO-1:0] oQ,
    output logic [wI-1:0] oR,
    output logic          oDivZero
);

    localparam int CW = $clog2(wO);

    karat_state_e  state_q, state_d;
    logic [wO-1:0] dvd_q, dvd_d;
    logic [wI-1:0] rem_q, rem_d;
    logic [wI-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic [wI-1:0] step_rem;
    logic          step_qbit;
    logic          accept;

    assign accept = iValid && (state_q == IDLE);

    karat_div_step #(.wI(wI)) u_step (
        .rem      (rem_q),
        .msb      (dvd_q[wO-1]),
        .y        (y_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (iY == '0) ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The dividend register shifts quotient bits in from the bottom, so it
    // holds the full quotient once the last iteration has run.
    always_comb begin
        dvd_d = dvd_q;
        rem_d = rem_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        dz_d  = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d   = iY;
                    cnt_d = CW'(wO - 1);
                    if (iY == '0) begin
                        dvd_d = '1;
                        rem_d = iO[wI-1:0];
                        dz_d  = 1'b1;
                    end else begin
                        dvd_d = iO;
                        rem_d = '0;
                        dz_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[wO-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        oReady   = (state_q == IDLE);
        oValid   = (state_q == DONE);
        oQ       = dvd_q;
        oR       = rem_q;
        oDivZero = dz_q;
    end

endmodule

// File: tb/tb_karat_div.sv
// Directed and randomised checks for karat_div: vector table, backpressure,
// mid-division reset and multiply/divide round trips.
module tb_karat_div;

    localparam int WI = 64;
    localparam int WO = 128;

    typedef struct {
        logic [WO-1:0] o;
        logic [WI-1:0] y;
        logic [WO-1:0] q;
        logic [WI-1:0] r;
        logic          dz;
    } vec_t;

    logic          iClk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iValid = 1'b0;
    logic          oReady;
    logic [WO-1:0] iO = '0;
    logic [WI-1:0] iY = '0;
    logic          oValid;
    logic          iReady = 1'b0;
    logic [WO-1:0] oQ;
    logic [WI-1:0] oR;
    logic          oDivZero;

    int total = 0;
    int bad   = 0;

    karat_div #(.wI(WI), .wO(WO)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iValid   (iValid),
        .oReady   (oReady),
        .iO       (iO),
        .iY       (iY),
        .oValid   (oValid),
        .iReady   (iReady),
        .oQ       (oQ),
        .oR       (oR),
        .oDivZero (oDivZero)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for oReady, issues one request, and returns the number
    // of rising edges after the accept edge until oValid is seen.
    task automatic run_div(input logic [WO-1:0] o, input logic [WI-1:0] y, output int lat);
        int w;
        w = 0;
        while (!oReady && w < 400) begin
            @(negedge iClk);
            w++;
        end
        @(negedge iClk);
        iO     = o;
        iY     = y;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        lat = 0;
        while (!oValid && lat < 400) begin
            @(posedge iClk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge iClk);
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        iReady = 1'b0;
    endtask

    initial begin
        vec_t          v[10];
        int            lat;
        logic          ok;
        logic [WI-1:0] x, y;
        logic [WO-1:0] p, eq, er;

        v[0] = '{128'd100, 64'd7, 128'd14, 64'd2, 1'b0};
        v[1] = '{{WO{1'b1}}, 64'd1, {WO{1'b1}}, 64'd0, 1'b0};
        v[2] = '{{WO{1'b1}}, {WI{1'b1}}, {64'd1, 64'd1}, 64'd0, 1'b0};
        v[3] = '{128'h1234, 64'd0, {WO{1'b1}}, 64'h1234, 1'b1};
        v[4] = '{128'd36, 64'd6, 128'd6, 64'd0, 1'b0};
        v[5] = '{128'd0, 64'd5, 128'd0, 64'd0, 1'b0};
        v[6] = '{128'd5, 64'd9, 128'd0, 64'd5, 1'b0};
        v[7] = '{{64'd1, 64'd5}, 64'h8000_0000_0000_0000, 128'd2, 64'd5, 1'b0};
        v[8] = '{{{WI{1'b1}}, 64'd0}, {WI{1'b1}}, {64'd1, 64'd0}, 64'd0, 1'b0};
        v[9] = '{{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, 64'd0,
                 {WO{1'b1}}, 64'h5555_6666_7777_8888, 1'b1};

        #2;
        chk("rst_ready", oReady, 1);
        chk("rst_valid", oValid, 0);
        chk("rst_q", oQ, 0);
        chk("rst_r", oR, 0);
        chk("rst_dz", oDivZero, 0);
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div(v[i].o, v[i].y, lat);
            chk($sformatf("vec%0d_lat", i), lat, v[i].dz ? 0 : WO);
            chk($sformatf("vec%0d_q", i), oQ, v[i].q);
            chk($sformatf("vec%0d_r", i), oR, v[i].r);
            chk($sformatf("vec%0d_dz", i), oDivZero, v[i].dz);
            chk($sformatf("vec%0d_busy", i), oReady, 0);
            drain();
            chk($sformatf("vec%0d_idle", i), oReady, 1);
        end

        // Backpressure: hold off the consumer and poke iValid mid-way.
        run_div(128'd100, 64'd7, lat);
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge iClk);
            iValid = (c == 10);
            iO     = 128'd5;
            iY     = 64'd1;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oQ !== 128'd14 ||
                oR !== 64'd2 || oDivZero !== 1'b0)
                ok = 1'b0;
        end
        iValid = 1'b0;
        chk("bp_stable", ok, 1);
        drain();
        chk("bp_ready", oReady, 1);
        chk("bp_valid", oValid, 0);
        repeat (3) @(posedge iClk);
        #1;
        chk("bp_stay_idle", oReady, 1);

        // Reset partway through a division.
        @(negedge iClk);
        iO     = 128'd1000;
        iY     = 64'd3;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        repeat (60) @(posedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        chk("rstmid_valid", oValid, 0);
        chk("rstmid_ready", oReady, 1);
        chk("rstmid_q", oQ, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 140; c++) begin
            @(negedge iClk);
            if (oValid !== 1'b0) ok = 1'b0;
        end
        chk("rstmid_no_result", ok, 1);
        run_div(128'd36, 64'd6, lat);
        chk("rstmid_after_q", oQ, 6);
        chk("rstmid_after_r", oR, 0);
        drain();

        for (int i = 0; i < 16; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i % 2 == 1) y = y >> $urandom_range(0, 60);
            if (y == '0) y = 64'd1;
            p = WO'(x) * WO'(y);
            run_div(p, y, lat);
            chk($sformatf("rt%0d_q", i), oQ, WO'(x));
            chk($sformatf("rt%0d_r", i), oR, 0);
            drain();

            p  = {$urandom, $urandom, $urandom, $urandom};
            eq = p / WO'(y);
            er = p % WO'(y);
            run_div(p, y, lat);
            chk($sformatf("rnd%0d_q", i), oQ, eq);
            chk($sformatf("rnd%0d_r", i), oR, er);
            chk($sformatf("rnd%0d_lat", i), lat, WO);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
